// File: rtl/miriscv_opcodes_pkg.sv
// Shared RV32I opcode constants (instr[6:2]) and the opcode -> immediate-format map
// used by both the decoder and the immediate encoder.
package miriscv_opcodes_pkg;

  localparam logic [4:0] S_OPCODE_LOAD     = 5'b00000;
  localparam logic [4:0] S_OPCODE_MISC_MEM = 5'b00011;
  localparam logic [4:0] S_OPCODE_OPIMM    = 5'b00100;
  localparam logic [4:0] S_OPCODE_AUIPC    = 5'b00101;
  localparam logic [4:0] S_OPCODE_STORE    = 5'b01000;
  localparam logic [4:0] S_OPCODE_OP       = 5'b01100;
  localparam logic [4:0] S_OPCODE_LUI      = 5'b01101;
  localparam logic [4:0] S_OPCODE_BRANCH   = 5'b11000;
  localparam logic [4:0] S_OPCODE_JALR     = 5'b11001;
  localparam logic [4:0] S_OPCODE_JAL      = 5'b11011;
  localparam logic [4:0] S_OPCODE_SYSTEM   = 5'b11100;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
  } imm_fmt_e;

  // One encoded word travelling through the output/skid registers.
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_word_t;

  function automatic imm_fmt_e opcode_to_fmt(input logic [4:0] op);
    imm_fmt_e f;
    case (op)
      S_OPCODE_OPIMM, S_OPCODE_LOAD, S_OPCODE_JALR: f = FMT_I;
      S_OPCODE_OP:                                  f = FMT_R;
      S_OPCODE_STORE:                               f = FMT_S;
      S_OPCODE_BRANCH:                              f = FMT_B;
      S_OPCODE_LUI, S_OPCODE_AUIPC:                 f = FMT_U;
      S_OPCODE_JAL:                                 f = FMT_J;
      default:                                      f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/miriscv_imm_enc_if.sv
// Request/response bundle of the immediate encoder; master drives requests,
// slave (the encoder) returns encoded words.
interface miriscv_imm_enc_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [4:0]       opcode_i;
  logic [4:0]       rd_i;
  logic [4:0]       rs1_i;
  logic [4:0]       rs2_i;
  logic [2:0]       funct3_i;
  logic [6:0]       funct7_i;
  logic [XLEN-1:0]  imm_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [31:0]      instr_o;
  logic             err_o;
  logic [CNT_W-1:0] err_cnt_o;

  modport master (
    output in_valid_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, out_ready_i,
    input  in_ready_o, out_valid_o, instr_o, err_o, err_cnt_o
  );

  modport slave (
    input  in_valid_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, out_ready_i,
    output in_ready_o, out_valid_o, instr_o, err_o, err_cnt_o
  );
endinterface

// File: rtl/miriscv_imm_pack.sv
// Combinational packer: scatters fields and immediate into an RV32I word for the
// given format and flags immediates that do not fit or are misaligned.
module miriscv_imm_pack
  import miriscv_opcodes_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  imm_fmt_e        fmt,
  input  logic [4:0]      opcode,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] imm,
  output logic [31:0]     instr,
  output logic            err
);

  logic [6:0] base;
  logic       fit12, fit13, fit21;

  assign base  = {opcode, 2'b11};
  assign fit12 = (imm == {{(XLEN-12){imm[11]}}, imm[11:0]});
  assign fit13 = (imm == {{(XLEN-13){imm[12]}}, imm[12:0]});
  assign fit21 = (imm == {{(XLEN-21){imm[20]}}, imm[20:0]});

  // Field placement per format; on a range error the truncated fields still go out.
  always_comb begin
    instr = {25'b0, base};
    err   = 1'b0;
    case (fmt)
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, base};
      FMT_I: begin
        instr = {imm[11:0], rs1, funct3, rd, base};
        err   = !fit12;
      end
      FMT_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], base};
        err   = !fit12;
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], base};
        err   = !fit13 || imm[0];
      end
      FMT_U: begin
        instr = {imm[31:12], rd, base};
        err   = |imm[11:0];
      end
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, base};
        err   = !fit21 || imm[0];
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/miriscv_imm_enc.sv
// Streaming RV32I instruction encoder: packer feeding an output register backed by
// one skid entry, plus a saturating count of errored words delivered.
module miriscv_imm_enc
  import miriscv_opcodes_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  miriscv_imm_enc_if.slave    bus
);

  imm_fmt_e         fmt;
  enc_word_t        pack_w, out_q, skid_q;
  logic             out_valid_q, skid_valid_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic             acc, drain;

  assign fmt   = opcode_to_fmt(bus.opcode_i);
  // Skid occupancy is the only thing that can block input, so ready is a pure flop.
  assign acc   = bus.in_valid_i && !skid_valid_q;
  assign drain = out_valid_q && bus.out_ready_i;

  miriscv_imm_pack #(.XLEN(XLEN)) u_pack (
    .fmt    (fmt),
    .opcode (bus.opcode_i),
    .rd     (bus.rd_i),
    .rs1    (bus.rs1_i),
    .rs2    (bus.rs2_i),
    .funct3 (bus.funct3_i),
    .funct7 (bus.funct7_i),
    .imm    (bus.imm_i),
    .instr  (pack_w.instr),
    .err    (pack_w.err)
  );

  // Output register refills from skid first (FIFO order), else from the packer;
  // an accept while the output is stuck parks in the skid entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_q        <= skid_q;
        skid_valid_q <= 1'b0;
      end else if (acc) begin
        out_valid_q <= 1'b1;
        out_q       <= pack_w;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (acc) begin
      skid_valid_q <= 1'b1;
      skid_q       <= pack_w;
    end
  end

  // Count errored words as they leave, holding at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      err_cnt_q <= '0;
    else if (drain && out_q.err && !(&err_cnt_q))
      err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign bus.in_ready_o  = !skid_valid_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.instr_o     = out_q.instr;
  assign bus.err_o       = out_q.err;
  assign bus.err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_miriscv_imm_enc.sv
// Bench for miriscv_imm_enc: directed encodings, range errors, async reset with
// full buffering, backpressure and a randomized stream against a reference model.
module tb_miriscv_imm_enc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  miriscv_imm_enc_if #(.XLEN(32), .CNT_W(16)) bus ();
  miriscv_imm_enc #(.XLEN(32), .CNT_W(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op, rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    req_t        r;
    logic [31:0] exp;
    logic        eerr;
  } vec_t;

  task automatic drive(input req_t r, input logic v);
    bus.in_valid_i = v;
    bus.opcode_i   = r.op;
    bus.rd_i       = r.rd;
    bus.rs1_i      = r.rs1;
    bus.rs2_i      = r.rs2;
    bus.funct3_i   = r.f3;
    bus.funct7_i   = r.f7;
    bus.imm_i      = r.imm;
  endtask

  task automatic apply_reset();
    req_t z = '{default: '0};
    drive(z, 1'b0);
    bus.out_ready_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference: builds the word with shifts/masks and checks ranges with integers.
  function automatic logic [32:0] ref_enc(input req_t r);
    logic [31:0] w, im;
    logic        e;
    int          s;
    im = r.imm;
    s  = $signed(r.imm);
    w  = 32'(r.op) * 4 + 3;
    e  = 1'b0;
    case (r.op)
      5'b00000, 5'b00100, 5'b11001: begin
        w |= ((im & 32'hFFF) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12) | (32'(r.rd) << 7);
        e = (s < -2048) || (s > 2047);
      end
      5'b01100:
        w |= (32'(r.f7) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12) | (32'(r.rd) << 7);
      5'b01000: begin
        w |= (((im >> 5) & 32'h7F) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12) | ((im & 32'h1F) << 7);
        e = (s < -2048) || (s > 2047);
      end
      5'b11000: begin
        w |= (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15)
           | (32'(r.f3) << 12) | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7);
        e = (s < -4096) || (s > 4095) || ((im % 2) != 0);
      end
      5'b00101, 5'b01101: begin
        w |= (im & 32'hFFFFF000) | (32'(r.rd) << 7);
        e = (im % 4096) != 0;
      end
      5'b11011: begin
        w |= (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 1) << 20)
           | (((im >> 12) & 32'hFF) << 12) | (32'(r.rd) << 7);
        e = (s < -1048576) || (s > 1048575) || ((im % 2) != 0);
      end
      default: e = 1'b1;
    endcase
    return {e, w};
  endfunction

  function automatic req_t rand_req();
    logic [4:0] ops [12] = '{5'b00000, 5'b00100, 5'b11001, 5'b01100, 5'b01000, 5'b11000,
                             5'b00101, 5'b01101, 5'b11011, 5'b11100, 5'b00011, 5'b11111};
    int bnd [14] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                     1048574, 1048576, -1048576, 4096, 0, 1};
    req_t r;
    r.op  = ops[$urandom_range(0, 11)];
    r.rd  = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    r.f3  = 3'($urandom);
    r.f7  = 7'($urandom);
    case ($urandom_range(0, 3))
      0: r.imm = $urandom;
      1: r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: r.imm = 32'(bnd[$urandom_range(0, 13)]);
      default: r.imm = $urandom & 32'hFFFFF000;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    req_t z = '{default: '0};
    drive(z, 1'b0);
    bus.out_ready_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid_o); end
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready_o); end
    total++; if (bus.instr_o !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", bus.instr_o); end
    total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err_o); end
    total++; if (bus.err_cnt_o !== 16'h0) begin bad++; $display("FAIL reset_err_cnt got=%0d want=0", bus.err_cnt_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_encode();
    req_t z = '{default: '0};
    vec_t v [5] = '{
      '{'{5'b00100, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF}, 32'hFFF10093, 1'b0},
      '{'{5'b01000, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'd8}, 32'h00512423, 1'b0},
      '{'{5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC}, 32'hFE000EE3, 1'b0},
      '{'{5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800}, 32'h001000EF, 1'b0},
      '{'{5'b01101, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000}, 32'h123451B7, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      drive(v[i].r, 1'b1);
      bus.out_ready_i = 1'b1;
      total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL enc%0d_in_ready got=%b want=1", i, bus.in_ready_o); end
      @(negedge clk);
      drive(z, 1'b0);
      total++; if (bus.out_valid_o !== 1'b1) begin bad++; $display("FAIL enc%0d_latency got=%b want=1", i, bus.out_valid_o); end
      total++; if (bus.instr_o !== v[i].exp) begin bad++; $display("FAIL enc%0d_instr got=%h want=%h", i, bus.instr_o, v[i].exp); end
      total++; if (bus.err_o !== v[i].eerr) begin bad++; $display("FAIL enc%0d_err got=%b want=%b", i, bus.err_o, v[i].eerr); end
      @(negedge clk);
      total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL enc%0d_drained got=%b want=0", i, bus.out_valid_o); end
    end
  endtask

  task automatic test_errors();
    req_t z = '{default: '0};
    vec_t v [3] = '{
      '{'{5'b00100, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048}, 32'h80010093, 1'b1},
      '{'{5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6}, 32'h00000363, 1'b0},
      '{'{5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3}, 32'h002000EF, 1'b1}};
    for (int i = 0; i < 3; i++) begin
      drive(v[i].r, 1'b1);
      bus.out_ready_i = 1'b1;
      @(negedge clk);
      drive(z, 1'b0);
      total++; if (bus.out_valid_o !== 1'b1) begin bad++; $display("FAIL err%0d_valid got=%b want=1", i, bus.out_valid_o); end
      total++; if (bus.instr_o !== v[i].exp) begin bad++; $display("FAIL err%0d_instr got=%h want=%h", i, bus.instr_o, v[i].exp); end
      total++; if (bus.err_o !== v[i].eerr) begin bad++; $display("FAIL err%0d_flag got=%b want=%b", i, bus.err_o, v[i].eerr); end
      @(negedge clk);
    end
    total++; if (bus.err_cnt_o !== 16'd2) begin bad++; $display("FAIL err_cnt got=%0d want=2", bus.err_cnt_o); end
  endtask

  task automatic test_async_reset();
    req_t z = '{default: '0};
    req_t a = '{5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3};
    req_t c = '{5'b01101, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000};
    bus.out_ready_i = 1'b0;
    drive(a, 1'b1);
    @(negedge clk);
    drive(c, 1'b1);
    @(negedge clk);
    drive(z, 1'b0);
    total++; if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL arst_full got=%b want=0", bus.in_ready_o); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b want=0", bus.out_valid_o); end
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL arst_in_ready got=%b want=1", bus.in_ready_o); end
    total++; if (bus.err_cnt_o !== 16'd0) begin bad++; $display("FAIL arst_err_cnt got=%0d want=0", bus.err_cnt_o); end
    @(negedge clk);
    rst = 1'b0;
    drive(c, 1'b1);
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    drive(z, 1'b0);
    total++; if (bus.out_valid_o !== 1'b1) begin bad++; $display("FAIL arst_post_valid got=%b want=1", bus.out_valid_o); end
    total++; if (bus.instr_o !== 32'h123451B7) begin bad++; $display("FAIL arst_post_instr got=%h want=123451b7", bus.instr_o); end
    @(negedge clk);
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL arst_no_stale got=%b want=0", bus.out_valid_o); end
  endtask

  task automatic test_backpressure();
    req_t        rq [4];
    req_t        z = '{default: '0};
    logic [32:0] q [$];
    logic [32:0] e;
    int          acc_n = 0, del_n = 0, second = -10;
    logic        rdy, ordy;
    apply_reset();
    for (int i = 0; i < 4; i++) rq[i] = rand_req();
    for (int cyc = 0; cyc < 40 && del_n < 4; cyc++) begin
      rdy = (q.size() < 2);
      total++; if (bus.in_ready_o !== rdy) begin bad++; $display("FAIL bp_in_ready c%0d got=%b want=%b", cyc, bus.in_ready_o, rdy); end
      total++; if (bus.out_valid_o !== (q.size() > 0)) begin bad++; $display("FAIL bp_out_valid c%0d got=%b want=%b", cyc, bus.out_valid_o, q.size() > 0); end
      if (cyc == second + 1) begin
        total++; if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready_drop got=%b want=0", bus.in_ready_o); end
      end
      ordy = (cyc >= 3);
      bus.out_ready_i = ordy;
      if (acc_n < 4) drive(rq[acc_n], 1'b1); else drive(z, 1'b0);
      if (ordy && q.size() > 0) begin
        e = q.pop_front();
        total++; if ({bus.err_o, bus.instr_o} !== e) begin bad++; $display("FAIL bp_word%0d got=%b/%h want=%b/%h", del_n, bus.err_o, bus.instr_o, e[32], e[31:0]); end
        del_n++;
      end
      if (acc_n < 4 && rdy) begin
        q.push_back(ref_enc(rq[acc_n]));
        acc_n++;
        if (acc_n == 2) second = cyc;
      end
      @(negedge clk);
    end
    drive(z, 1'b0);
    total++; if (del_n !== 4) begin bad++; $display("FAIL bp_delivered got=%0d want=4", del_n); end
  endtask

  task automatic test_random();
    req_t        cur;
    req_t        z = '{default: '0};
    logic [32:0] q [$];
    logic [32:0] e;
    int          sent = 0, del_n = 0, nerr = 0, cyc = 0;
    logic        pend = 1'b0, rdy, ordy;
    localparam int N = 300;
    apply_reset();
    while (del_n < N && cyc < 4000) begin
      rdy = (q.size() < 2);
      total++; if (bus.in_ready_o !== rdy) begin bad++; $display("FAIL rnd_in_ready c%0d got=%b want=%b", cyc, bus.in_ready_o, rdy); end
      total++; if (bus.out_valid_o !== (q.size() > 0)) begin bad++; $display("FAIL rnd_out_valid c%0d got=%b want=%b", cyc, bus.out_valid_o, q.size() > 0); end
      if (!pend && sent < N && $urandom_range(0, 3) != 0) begin
        cur  = rand_req();
        pend = 1'b1;
      end
      if (pend) drive(cur, 1'b1); else drive(z, 1'b0);
      ordy = ($urandom_range(0, 2) != 0);
      bus.out_ready_i = ordy;
      if (ordy && q.size() > 0) begin
        e = q.pop_front();
        total++; if ({bus.err_o, bus.instr_o} !== e) begin bad++; $display("FAIL rnd_word%0d got=%b/%h want=%b/%h", del_n, bus.err_o, bus.instr_o, e[32], e[31:0]); end
        if (e[32]) nerr++;
        del_n++;
      end
      if (pend && rdy) begin
        q.push_back(ref_enc(cur));
        pend = 1'b0;
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    drive(z, 1'b0);
    bus.out_ready_i = 1'b0;
    total++; if (del_n !== N) begin bad++; $display("FAIL rnd_timeout got=%0d want=%0d", del_n, N); end
    total++; if (bus.err_cnt_o !== 16'(nerr)) begin bad++; $display("FAIL rnd_err_cnt got=%0d want=%0d", bus.err_cnt_o, nerr); end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_errors();
    test_async_reset();
    test_backpressure();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/miriscv_imm_enc.md
Name: miriscv_imm_enc

Overview:
- Streaming instruction encoder, the inverse of the core's immediate decode. It takes an opcode field, register indices, function fields and a full-width immediate, and packs them into a 32-bit RV32I instruction word.
- Each immediate is range- and alignment-checked against its format; violations are flagged per instruction.
- Sits in the test/boot infrastructure, e.g. trap-stub generation and instruction injection for the debug path.
- Valid/ready on both sides, registered output, full throughput.

Parameters:
- XLEN, 32, width of imm_i; only 32 is supported.
- CNT_W, 16, width of the error counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- in_valid_i  in  1  request valid
- in_ready_o  out  1  encoder can accept; registered
- opcode_i  in  5  instr[6:2] class (package S_OPCODE_* constants)
- rd_i  in  5  destination register
- rs1_i  in  5  source register 1
- rs2_i  in  5  source register 2
- funct3_i  in  3  funct3
- funct7_i  in  7  funct7 (R-type only)
- imm_i  in  XLEN  signed immediate, byte offset for B/J; for U, the final value with [11:0]=0
- out_valid_o  out  1  instr_o valid
- out_ready_i  in  1  consumer accepts
- instr_o  out  32  encoded instruction
- err_o  out  1  imm_i out of range/misaligned, or opcode unsupported; qualified by out_valid_o
- err_cnt_o  out  CNT_W  count of errored instructions delivered, saturating

Behaviour:
- Reset (async, rst_i=1): out_valid_o=0, instr_o=0, err_o=0, err_cnt_o=0, in_ready_o=1, skid buffer empty. Any transfer in flight at reset is discarded.
- Encoding: instr[1:0]=2'b11 and instr[6:2]=opcode_i for every instruction.
- OPIMM/LOAD/JALR (I-type): imm[11:0] | rs1 | funct3 | rd.
- OP (R-type): funct7 | rs2 | rs1 | funct3 | rd; imm_i is ignored and never flags an error.
- STORE (S-type): imm[11:5] | rs2 | rs1 | funct3 | imm[4:0].
- BRANCH (B-type): imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11].
- LUI/AUIPC (U-type): imm[31:12] | rd.
- JAL (J-type): imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd.
- Range and alignment checks (err=1 on violation):
  - I/S: imm_i must equal the sign-extension of imm_i[11:0].
  - B: imm_i must equal the sign-extension of imm_i[12:0], and imm_i[0]=0.
  - J: imm_i must equal the sign-extension of imm_i[20:0], and imm_i[0]=0.
  - U: imm_i[11:0]=0.
- On error the word is still emitted with the truncated fields; err_o=1.
- Unsupported opcode: instr_o = {25'b0, opcode_i, 2'b11}, err_o=1.
- Handshake: transfer occurs when valid && ready. in_valid_i must hold and inputs stay stable until accepted. out_valid_o/instr_o/err_o hold stable until out_ready_i=1.
- Latency: exactly 1 cycle from input acceptance to out_valid_o when the output register is empty or draining in the same cycle.
- Throughput: 1 instruction/cycle with out_ready_i=1.
- Buffering: one output register plus one skid entry. in_ready_o = !skid_valid, registered.
  - Input accepted while output full and not draining → entry goes to skid; in_ready_o drops the next cycle.
  - Skid moves to output when the output drains. Simultaneous accept and drain with skid occupied cannot happen, since in_ready_o=0.
- Ordering is strictly FIFO.
- Counter: err_cnt_o increments on each output transfer (out_valid_o && out_ready_i) with err_o=1, and saturates at all-ones.

Decomposition:
- Shared package: reuse the S_OPCODE_* constants from miriscv_opcodes_pkg. Add there a format enum imm_fmt_e {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE} and a function opcode_to_fmt() so the decoder and encoder share one opcode→format map.
- One combinational sub-module, miriscv_imm_pack: fmt, fields and imm in → 32-bit word and err out. The top holds the skid/output registers and the counter.

Test Plan:
- OPIMM, rd=1, rs1=2, funct3=0, imm=32'hFFFFFFFF → instr_o=32'hFFF10093, err_o=0, out_valid_o one cycle after accept.
- STORE, rs1=2, rs2=5, funct3=3'b010, imm=8 → 32'h00512423; BRANCH, rs1=rs2=0, funct3=0, imm=-4 → 32'hFE000EE3.
- JAL, rd=1, imm=32'h800 → 32'h001000EF; LUI, rd=3, imm=32'h12345000 → 32'h123451B7.
- Range and alignment errors:
  - OPIMM imm=2048 → err_o=1, imm field=12'h800.
  - BRANCH imm=6 (in range) → err_o=0.
  - JAL imm=3 → err_o=1.
  - err_cnt_o=2 after both errored outputs transfer.
- Backpressure: stream 4 back-to-back requests, out_ready_i=0 for 3 cycles → in_ready_o=0 from the cycle after the 2nd accept; then drain → all 4 words out in order, no loss or duplication.
- Assert rst_i asynchronously with output and skid full → out_valid_o=0 and in_ready_o=1 immediately; err_cnt_o=0; the first post-reset request encodes correctly.
